// File: rtl/adder2_sequencer.sv
// Multi-cycle WIDTH-bit adder driving an external 2-bit `adder2` slice, LSB slice first.
// Optional macro ADDER2_SEQ_BACK_TO_BACK_EN: accept new operands while handing off a result.
module adder2_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             rx_clk,
   input  logic             rx_resetn,
   input  logic             rx_valid,
   output logic             tx_ready,
   input  logic             rx_carryflag,
   input  logic [WIDTH-1:0] rx_addend0,
   input  logic [WIDTH-1:0] rx_addend1,
   output logic             tx_valid,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] tx_sum,
   output logic             tx_carryflag,
   output logic             tx_zeroflag,
   output logic             tx_slice_enable,
   output logic             tx_slice_carryflag,
   output logic [1:0]       tx_slice_addend0,
   output logic [1:0]       tx_slice_addend1,
   input  logic [1:0]       rx_slice_sum,
   input  logic             rx_slice_carryflag,
   input  logic             rx_slice_zeroflag
);

   localparam int unsigned SLICES = WIDTH / 2;
   localparam int unsigned KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
         $error("adder2_sequencer: WIDTH must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op0_q, op1_q, sum_q;
   logic             carry_q, zero_q;
   logic [KW-1:0]    k_q;
   logic             accept;
   logic             last_slice;
   logic [WIDTH+1:0] sum_shift;

   assign last_slice = (k_q == KW'(SLICES - 1));
   // Operands shift down and slice sums shift in from the top instead of indexing by k;
   // after SLICES steps the first slice sum has reached bit 0.
   assign sum_shift  = {rx_slice_sum, sum_q};

   always_comb begin
      state_d            = state_q;
      accept             = 1'b0;
      tx_ready           = 1'b0;
      tx_valid           = 1'b0;
      tx_sum             = '0;
      tx_carryflag       = 1'b0;
      tx_zeroflag        = 1'b0;
      tx_slice_enable    = 1'b0;
      tx_slice_carryflag = 1'b0;
      tx_slice_addend0   = '0;
      tx_slice_addend1   = '0;
      case (state_q)
         IDLE: begin
            tx_ready = rx_resetn;
            if (rx_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            tx_slice_enable    = 1'b1;
            tx_slice_carryflag = carry_q;
            tx_slice_addend0   = op0_q[1:0];
            tx_slice_addend1   = op1_q[1:0];
            if (last_slice) begin
               state_d = DONE;
            end
         end
         DONE: begin
            tx_valid     = 1'b1;
            tx_sum       = sum_q;
            tx_carryflag = carry_q;
            tx_zeroflag  = zero_q;
`ifdef ADDER2_SEQ_BACK_TO_BACK_EN
            tx_ready = rx_ready;
            if (rx_ready) begin
               accept  = rx_valid;
               state_d = rx_valid ? RUN : IDLE;
            end
`else
            if (rx_ready) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rx_clk or negedge rx_resetn) begin
      if (!rx_resetn) begin
         state_q <= IDLE;
         op0_q   <= '0;
         op1_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op0_q   <= rx_addend0;
            op1_q   <= rx_addend1;
            carry_q <= rx_carryflag;
            sum_q   <= '0;
            zero_q  <= 1'b1;
            k_q     <= '0;
         end else if (state_q == RUN) begin
            op0_q   <= op0_q >> 2;
            op1_q   <= op1_q >> 2;
            sum_q   <= sum_shift[WIDTH+1:2];
            carry_q <= rx_slice_carryflag;
            zero_q  <= zero_q & rx_slice_zeroflag;
            k_q     <= last_slice ? '0 : k_q + KW'(1);
         end
      end
   end

endmodule

// File: doc/adder2_sequencer.md
# adder2_sequencer

- Multi-cycle WIDTH-bit adder that feeds the combinational `adder2` 2-bit slice directly upstream.
- Accepts one pair of WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Presents one 2-bit slice per cycle, LSB first, to `adder2`, chaining carry through a register, and assembles the captured slice sums.
- Returns the full sum, carry-out and zero flag downstream over a second valid/ready handshake.

## Interface
- WIDTH, 8, operand/sum width in bits; must be even and ≥2 (elaboration error otherwise)
- rx_clk  input  1  clock; all state changes on rising edge
- rx_resetn  input  1  asynchronous, active-low reset
- rx_valid  input  1  upstream operands valid
- tx_ready  output  1  block can accept operands
- rx_carryflag  input  1  carry-in
- rx_addend0  input  WIDTH  first operand
- rx_addend1  input  WIDTH  second operand
- tx_valid  output  1  result valid
- rx_ready  input  1  downstream accepts result
- tx_sum  output  WIDTH  result sum
- tx_carryflag  output  1  result carry-out
- tx_zeroflag  output  1  high when tx_sum == 0 (carry-out ignored)
- tx_slice_enable  output  1  to `adder2` rx_enable
- tx_slice_carryflag  output  1  to `adder2` rx_carryflag
- tx_slice_addend0  output  2  to `adder2` rx_addend0
- tx_slice_addend1  output  2  to `adder2` rx_addend1
- rx_slice_sum  input  2  from `adder2` tx_sum
- rx_slice_carryflag  input  1  from `adder2` tx_carryflag
- rx_slice_zeroflag  input  1  from `adder2` tx_zeroflag

## Operation
- States: IDLE, RUN, DONE. Registers: operand copies, carry reg, sum reg, zero accumulator, slice index k (0..WIDTH/2-1).
- IDLE
  - tx_ready=1, tx_valid=0.
  - On rx_valid&tx_ready: latch operands and carry-in into carry reg, clear sum reg, set zero accumulator to 1, k←0, go to RUN.
- RUN
  - tx_slice_enable=1; tx_slice_addend0/1 = latched operand bits [2k+1:2k]; tx_slice_carryflag = carry reg.
  - Each edge: sum reg[2k+1:2k]←rx_slice_sum; carry reg←rx_slice_carryflag; zero acc←zero acc & rx_slice_zeroflag; k←k+1.
  - On the edge where k=WIDTH/2-1, go to DONE.
- DONE
  - tx_valid=1; tx_sum=sum reg, tx_carryflag=carry reg, tx_zeroflag=zero acc, all held stable.
  - On rx_valid… no: on rx_ready, go to IDLE (or RUN, see Configuration).
- Outside RUN: tx_slice_enable=0, slice addends and carry driven 0.
- tx_sum, tx_carryflag and tx_zeroflag are 0 whenever tx_valid=0.
- Input changes during RUN and DONE are ignored; operands are latched.
- Arithmetic: tx_carryflag:tx_sum = rx_addend0 + rx_addend1 + rx_carryflag, modulo 2^(WIDTH+1).

## Timing
- Reset values (asynchronous, immediate on rx_resetn low):
  - state=IDLE, all registers 0.
  - tx_valid=0, tx_sum=0, tx_carryflag=0, tx_zeroflag=0.
  - tx_slice_*=0.
  - tx_ready=1 once rx_resetn is high; 0 while held in reset.
- Latency: tx_valid rises WIDTH/2 edges after the accept edge (4 for WIDTH=8).
- Throughput without macro: one op per WIDTH/2+2 cycles.
- The slice path is combinational (tx_slice_* → `adder2` → rx_slice_*) and is captured in the same cycle.
- Reset mid-RUN or mid-DONE aborts the operation: no tx_valid, result discarded.
- Backpressure: DONE persists indefinitely while rx_ready=0; tx_ready stays 0.

## Configuration
- ADDER2_SEQ_BACK_TO_BACK_EN
  - Defined: in DONE, tx_ready=rx_ready. On rx_ready&rx_valid, the result and the new operands are exchanged on the same edge, going straight to RUN; throughput is one op per WIDTH/2+1 cycles.
  - Undefined: tx_ready=1 only in IDLE.

## Test plan
- WIDTH=8, 0x5A+0x3C, cin=0, rx_ready=1 → tx_valid 4 edges after accept; sum=0x96, carry=0, zero=0.
- 0xFF+0x01, cin=0 → sum=0x00, carry=1, zero=1; tx_slice_enable high for exactly 4 cycles.
- 0xFF+0xFF, cin=1 → sum=0xFF, carry=1, zero=0. 0x00+0x00, cin=0 → sum=0x00, carry=0, zero=1.
- Backpressure: rx_ready=0 for 10 cycles in DONE → tx_valid, sum, carry and zero stable; tx_ready=0; operand changes ignored.
- Pull rx_resetn low after the 2nd RUN edge → outputs 0 immediately; after release, tx_ready=1 and no tx_valid.
- With ADDER2_SEQ_BACK_TO_BACK_EN: rx_valid and rx_ready held high, ops 0x01+0x01 then 0x80+0x80 → results 0x02/c0, then 0x00/c1/z1, 5 cycles apart.
